// File: rtl/regfile_pkg.sv
// regfile_pkg: register-file widths, special indices and write-permission helper
`ifndef DATA_BUS_SIZE
`define DATA_BUS_SIZE 8
`endif
`ifndef REG_ADDR_SIZE
`define REG_ADDR_SIZE 3
`endif
`ifndef REG_IN_IDX
`define REG_IN_IDX 1
`endif
`ifndef REG_OUT_IDX
`define REG_OUT_IDX 2
`endif
package regfile_pkg;
   localparam int DATA_W  = `DATA_BUS_SIZE;
   localparam int ADDR_W  = `REG_ADDR_SIZE;
   localparam int IN_IDX  = `REG_IN_IDX;
   localparam int OUT_IDX = `REG_OUT_IDX;
   // r0 is hardwired zero and the switch register is owned by the synchronizer
   function automatic logic writable(input int a, input int in_idx);
      return a != 0 && a != in_idx;
   endfunction
endpackage

// File: rtl/global_parameters.sv
// global_parameters: shared bus/address widths and register-file port indices
`ifndef GLOBAL_PARAMETERS_SV
`define GLOBAL_PARAMETERS_SV
`define DATA_BUS_SIZE 8
`define REG_ADDR_SIZE 3
`define REG_IN_IDX 1
`define REG_OUT_IDX 2
`endif

// File: rtl/regfile_sync2.sv
// sync2: parameterised-width two-flop synchronizer with sync active-high reset
module sync2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] s1;
   // two back-to-back flops to settle metastability on asynchronous inputs
   always_ff @(posedge clk)
      if (reset) begin
         s1 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
endmodule

// File: rtl/regfile.sv
// regfile: picoMIPS register file with Z/N flags, switch-input and LED-output registers
// Optional write-through bypass when REGFILE_BYPASS_EN is defined.
module regfile
   import regfile_pkg::*;
#(
   parameter int n       = DATA_W,
   parameter int m       = ADDR_W,
   parameter int IN_REG  = IN_IDX,
   parameter int OUT_REG = OUT_IDX
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [m-1:0]        ra1,
   input  logic [m-1:0]        ra2,
   output logic signed [n-1:0] rd1,
   output logic signed [n-1:0] rd2,
   input  logic                w,
   input  logic [m-1:0]        wa,
   input  logic [n-1:0]        wd,
   input  logic                flag_we,
   output logic                z_flag,
   output logic                n_flag,
   input  logic [n-1:0]        sw_in,
   output logic [n-1:0]        leds_out
);
   logic [n-1:0] r [2**m];
   logic [n-1:0] sw_s;
   logic         wr_ok;

   assign wr_ok = w && writable(int'(wa), IN_REG);

   sync2 #(.W(n)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sw_in),
      .q     (sw_s)
   );

   // architectural registers; the switch register reloads from the synchronizer every cycle
   always_ff @(posedge clk)
      if (reset) begin
         for (int i = 0; i < 2**m; i++) r[i] <= '0;
      end else begin
         if (wr_ok) r[wa] <= wd;
         r[IN_REG] <= sw_s;
      end

   // LED mirror updates on the same edge as the OUT_REG write
   always_ff @(posedge clk)
      if (reset) leds_out <= '0;
      else if (wr_ok && int'(wa) == OUT_REG) leds_out <= wd;

   // status flags track wd whenever flag_we is set, regardless of the write address
   always_ff @(posedge clk)
      if (reset) begin
         z_flag <= 1'b0;
         n_flag <= 1'b0;
      end else if (flag_we) begin
         z_flag <= wd == '0;
         n_flag <= wd[n-1];
      end

`ifdef REGFILE_BYPASS_EN
   // combinational reads with same-cycle forwarding of the pending write
   always_comb begin
      rd1 = ra1 == '0 ? '0 : (wr_ok && wa == ra1) ? wd : r[ra1];
      rd2 = ra2 == '0 ? '0 : (wr_ok && wa == ra2) ? wd : r[ra2];
   end
`else
   // combinational reads of stored values; r0 always reads zero
   always_comb begin
      rd1 = ra1 == '0 ? '0 : r[ra1];
      rd2 = ra2 == '0 ? '0 : r[ra2];
   end
`endif
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: scoreboard-driven self-checking bench for regfile
module tb_regfile;
   logic              clk = 0;
   logic              reset, w, flag_we, z_flag, n_flag;
   logic [2:0]        ra1, ra2, wa;
   logic signed [7:0] rd1, rd2;
   logic [7:0]        wd, sw_in, leds_out;

   typedef struct {
      string      tag;
      int         sel;
      logic [7:0] v;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0, n_bad = 0;
   logic [7:0] mdl [8];

   regfile dut (
      .clk      (clk),
      .reset    (reset),
      .ra1      (ra1),
      .ra2      (ra2),
      .rd1      (rd1),
      .rd2      (rd2),
      .w        (w),
      .wa       (wa),
      .wd       (wd),
      .flag_we  (flag_we),
      .z_flag   (z_flag),
      .n_flag   (n_flag),
      .sw_in    (sw_in),
      .leds_out (leds_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input int sel, input logic [7:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.v   = v;
      sb.push_back(e);
   endtask

   function automatic logic [7:0] obs(input int sel);
      return sel == 0 ? rd1 : sel == 1 ? rd2 : sel == 2 ? leds_out :
             sel == 3 ? {7'b0, z_flag} : {7'b0, n_flag};
   endfunction

   task automatic drain;
      #1;
      while (sb.size() > 0) begin
         exp_t e = sb.pop_front();
         check(e.tag, obs(e.sel), e.v);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1; w = 1; wa = 3; wd = 8'h55; flag_we = 0; sw_in = 0; ra1 = 3; ra2 = 1;
      tick;
      tick;
      push("rst_rd1", 0, 8'h00);
      push("rst_rd2", 1, 8'h00);
      push("rst_leds", 2, 8'h00);
      push("rst_z", 3, 8'h00);
      push("rst_n", 4, 8'h00);
      drain;
      reset = 0; w = 0;
      tick;
      push("r3_after_rst", 0, 8'h00);
      drain;
      w = 1; wa = 3; wd = 8'hA5;
      tick;
      w = 0; ra1 = 3; ra2 = 3;
      push("wr_rd1", 0, 8'hA5);
      push("wr_rd2", 1, 8'hA5);
      drain;
      w = 1; wa = 0; wd = 8'hFF;
      tick;
      w = 0; ra1 = 0;
      push("r0_zero", 0, 8'h00);
      push("r3_intact", 1, 8'hA5);
      drain;
      sw_in = 8'h3C; ra1 = 1;
      tick;
      push("sw_edge1", 0, 8'h00);
      drain;
      tick;
      push("sw_edge2", 0, 8'h00);
      drain;
      tick;
      push("sw_edge3", 0, 8'h3C);
      drain;
      w = 1; wa = 1; wd = 8'h11;
      tick;
      w = 0;
      push("sw_wr_ignored", 0, 8'h3C);
      drain;
      w = 1; wa = 2; wd = 8'h81;
      push("leds_before", 2, 8'h00);
      drain;
      tick;
      w = 0; wd = 8'h00; ra1 = 2;
      push("leds_same_edge", 2, 8'h81);
      push("r2_read", 0, 8'h81);
      drain;
      tick;
      push("leds_hold", 2, 8'h81);
      drain;
      flag_we = 1; wa = 0; wd = 8'h00;
      tick;
      push("z_on_zero", 3, 8'h01);
      push("n_on_zero", 4, 8'h00);
      drain;
      wd = 8'h80;
      tick;
      push("z_on_neg", 3, 8'h00);
      push("n_on_neg", 4, 8'h01);
      drain;
      flag_we = 0; wd = 8'h00;
      tick;
      push("z_hold", 3, 8'h00);
      push("n_hold", 4, 8'h01);
      drain;
      w = 1; wa = 4; wd = 8'h01;
      tick;
      wd = 8'h7E; ra1 = 4;
`ifdef REGFILE_BYPASS_EN
      push("same_cycle_rw", 0, 8'h7E);
`else
      push("same_cycle_rw", 0, 8'h01);
`endif
      drain;
      tick;
      w = 0;
      push("after_rw", 0, 8'h7E);
      drain;
      mdl = '{8'h00, 8'h3C, 8'h81, 8'hA5, 8'h7E, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 24; i++) begin
         w = 1; wa = 3'($urandom_range(0, 7)); wd = 8'($urandom);
         tick;
         if (wa != 0 && wa != 1) mdl[wa] = wd;
      end
      w = 0;
      for (int i = 0; i < 8; i++) begin
         ra1 = 3'(i); ra2 = 3'(7 - i);
         push($sformatf("rand_rd1_r%0d", i), 0, mdl[i]);
         push($sformatf("rand_rd2_r%0d", 7 - i), 1, mdl[7 - i]);
         push("rand_leds", 2, mdl[2]);
         drain;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- picoMIPS general-purpose register file, directly upstream of the ALU.
- Read ports feed the ALU operands `a`/`b`. The write port consumes the ALU `result` at the write-back edge.
- Holds architectural registers plus Z/N status flags for branch decode.
- Maps one register to a synchronized switch input and one to the LED output.

Parameters:
- n, `DATA_BUS_SIZE (8), register/data width.
- m, `REG_ADDR_SIZE (3), address width; 2**m registers.
- IN_REG, 1, register index driven by the synchronized switch input (read-only to the CPU).
- OUT_REG, 2, register index mirrored to leds_out.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- ra1  in  m  read address, port 1 (ALU operand a).
- ra2  in  m  read address, port 2 (ALU operand b).
- rd1  out  n  read data 1, signed.
- rd2  out  n  read data 2, signed.
- w  in  1  write enable.
- wa  in  m  write address.
- wd  in  n  write data (ALU result).
- flag_we  in  1  update Z/N flags from wd.
- z_flag  out  1  registered zero flag.
- n_flag  out  1  registered negative flag.
- sw_in  in  n  asynchronous switch inputs.
- leds_out  out  n  registered copy of register OUT_REG.

Behaviour:
- Reset (synchronous, active-high): at the next rising edge with reset=1, clear the following to 0:
  - all registers,
  - z_flag and n_flag,
  - both synchronizer stages,
  - leds_out.
- Reset overrides w, flag_we and sw loading in the same cycle.
- Register 0 is hardwired zero:
  - reads always return 0;
  - writes with wa=0 are discarded without error.
- Reads are combinational: rd1 = R[ra1] and rd2 = R[ra2], zero latency. Both ports may address the same register.
- Writes: at a rising edge with w=1, reset=0, wa not 0 and wa not IN_REG, R[wa] <= wd. The new value is visible on rd ports the cycle after the edge.
- IN_REG:
  - sw_in passes through a 2-flop synchronizer; R[IN_REG] <= sync output every cycle.
  - CPU writes to IN_REG are ignored; the switch load always wins.
  - A sw_in change reaches rd on the 3rd rising edge after it becomes stable.
- OUT_REG: leds_out <= value written to R[OUT_REG], i.e. leds_out updates at the same edge as the register, with no extra latency.
- Flags:
  - at an edge with flag_we=1, z_flag <= (wd == 0) and n_flag <= wd[n-1];
  - flags hold when flag_we=0;
  - flag_we is independent of w: flags update even if wa=0 (compare-style ops).
- Simultaneous events: a same-cycle read and write of one address returns the old value (no bypass, unless the optional feature is enabled).
- No X propagation: out-of-range addresses cannot occur, since 2**m registers are fully decoded.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through bypass. If w=1, wa=ra1 (or ra2), wa not 0 and wa not IN_REG, then rd1 (or rd2) = wd combinationally in the same cycle.
- Undefined: reads return the stored value; behaviour exactly as above.

Decomposition:
- `DATA_BUS_SIZE and `REG_ADDR_SIZE go in global_parameters.sv.
- IN_REG/OUT_REG default indices go in the same shared file as `REG_IN_IDX/`REG_OUT_IDX.
- One sub-module: sync2, a parameterised-width two-flop synchronizer with synchronous active-high reset, instantiated for sw_in.

Test Plan:
- Reset with w=1, wa=3, wd=8'h55 held -> all rd=0, flags=0, leds_out=0; R3 remains 0 after reset releases.
- Write wa=3, wd=8'hA5, then ra1=3, ra2=3 -> rd1=rd2=8'hA5 next cycle. Write wa=0, wd=8'hFF -> rd of ra1=0 stays 0.
- sw_in=8'h3C set mid-cycle, ra1=IN_REG -> rd1=8'h3C on the 3rd edge, not earlier. CPU write wa=IN_REG, wd=8'h11 -> rd1 stays 8'h3C.
- Write wa=OUT_REG, wd=8'h81 -> leds_out=8'h81 after the same edge; holds while w=0.
- flag_we=1, wd=8'h00 -> z=1, n=0. Then flag_we=1, wd=8'h80 -> z=0, n=1. Then flag_we=0, wd=8'h00 -> flags hold (z=0, n=1).
- Same-cycle write wa=4, wd=8'h7E with ra1=4 (old 8'h01) -> rd1=8'h01 without REGFILE_BYPASS_EN, 8'h7E with it.
